// File: rtl/posit_opgroup_out_fifo.sv
// posit_opgroup_out_fifo
//   Output buffer behind a posit opgroup format slice (DIVSQRT/NONCOMP). Captures
//   {result, status, extension bit, tag} on a valid/ready handshake into a
//   Depth-entry FIFO so the slice can retire while the result arbiter stalls.
//   in_ready_o depends only on the stored count, so there is no combinational
//   path from out_ready_i back to the slice.
//
// Parameters: Width (result bits), Depth (>= 2, any value), TagType (tag type).
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_*_i / in_valid_i   slice payload and valid; in_ready_o back to the slice
//   flush_i               discard all stored entries (wins over push/pop)
//   result_o, status_o, extension_bit_o, tag_o, out_valid_o / out_ready_i
//                         head entry towards the arbiter ('0 when empty)
//   busy_o                FIFO holds at least one entry
// Optional feature macro: POSIT_OUT_FIFO_STICKY_EN
//   adds sticky_clr_i / sticky_status_o, an OR of the status of every popped entry.

package posit_pkg;
  typedef struct packed {
    logic nv;  // invalid operation
    logic dz;  // divide by zero
    logic of;  // overflow
    logic uf;  // underflow
    logic nx;  // inexact
  } status_t;
endpackage

module posit_opgroup_out_fifo
  import posit_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 2,
  parameter type         TagType = logic
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_result_i,
  input  status_t          in_status_i,
  input  logic             in_ext_bit_i,
  input  TagType           in_tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [Width-1:0] result_o,
  output status_t          status_o,
  output logic             extension_bit_o,
  output TagType           tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
`ifdef POSIT_OUT_FIFO_STICKY_EN
  input  logic             sticky_clr_i,
  output status_t          sticky_status_o,
`endif
  output logic             busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop, not_empty;

  logic [Width-1:0] result_mem [Depth];
  status_t          status_mem [Depth];
  logic             ext_mem    [Depth];
  TagType           tag_mem    [Depth];

  // Pointer advance with wrap at Depth-1 so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake flags, all derived from registered state.
  assign not_empty   = (count_q != '0);
  assign in_ready_o  = (count_q != CntW'(Depth));
  assign out_valid_o = not_empty;
  assign busy_o      = not_empty;

  // Flush cancels both the same-cycle push and pop.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = not_empty & out_ready_i & ~flush_i;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; never cleared, validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      result_mem[wr_ptr_q] <= in_result_i;
      status_mem[wr_ptr_q] <= in_status_i;
      ext_mem[wr_ptr_q]    <= in_ext_bit_i;
      tag_mem[wr_ptr_q]    <= in_tag_i;
    end
  end

  // Head entry, masked to zero so stale storage never leaks out when empty.
  always_comb begin
    result_o        = '0;
    status_o        = '0;
    extension_bit_o = 1'b0;
    tag_o           = '0;
    if (not_empty) begin
      result_o        = result_mem[rd_ptr_q];
      status_o        = status_mem[rd_ptr_q];
      extension_bit_o = ext_mem[rd_ptr_q];
      tag_o           = tag_mem[rd_ptr_q];
    end
  end

`ifdef POSIT_OUT_FIFO_STICKY_EN
  status_t sticky_q;

  // Clear applies first, so a pop in the clearing cycle still lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_clr_i ? status_t'('0) : sticky_q) |
                  (pop ? status_o : status_t'('0));
    end
  end

  assign sticky_status_o = sticky_q;
`endif

endmodule
